rng_float_to_fixed: RTL and testbench
=====================================

Name: rng_float_to_fixed

Overview:
- Decoder for the RNG floating-point format: the opposite direction of the uniform-to-float converter.
- Takes a packed {exponent, mantissa} sample and reconstructs the BY-bit unsigned fixed-point fraction in [0,1) that it represents.
- Sits after the float RNG output in verification and analysis paths, and in consumers that need fixed-point samples.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- BY, 32: width of the reconstructed fixed-point fraction, binary point left of bit BY-1.
- MANT_BW, 8: stored mantissa bits, hidden leading one excluded; MANT_BW+1 <= BY.
- EXP_BW, 6: exponent field width; must satisfy 2^EXP_BW > BY.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_float carries a sample.
- in_ready, output, 1: block accepts in_float this cycle.
- in_float, input, EXP_BW+MANT_BW: {e[EXP_BW-1:0], m[MANT_BW-1:0]}.
- out_valid, output, 1: out_fixed/out_zero are valid.
- out_ready, input, 1: downstream accepts this cycle.
- out_fixed, output, BY: reconstructed fraction.
- out_zero, output, 1: sample decoded to exact zero (e >= BY).
- err, output, 1: sticky; set when any accepted sample has e > BY.

Behaviour:
- Format: e = count of leading zeros of the original uniform word; m = the MANT_BW bits following the leading one, MSB-first. e == BY encodes an all-zero word, and m is ignored.
- Decode: aligned = {1'b1, m, (BY-1-MANT_BW) zeros}; out_fixed = aligned >> e, logical shift, truncating (see optional feature).
- e == BY: out_fixed = 0, out_zero = 1.
- e > BY: out_fixed = 0, out_zero = 1, err set on the cycle the sample enters stage 2. err is cleared only by reset.
- Pipeline control:
  - Global enable en = out_ready | ~out_valid; in_ready = en, combinational.
  - Stage 1 (when en): register s1_valid <= in_valid, latch e, aligned, and an over-range flag.
  - Stage 2 (when en): barrel shift, zero/err detection. Register out_valid <= s1_valid plus the outputs.
  - Latency: exactly 2 clock edges from an accepted input to out_valid when out_ready stays high. Throughput is 1 sample per cycle.
  - Stall (out_valid & ~out_ready): all registers hold and in_ready = 0. A stage-1 bubble is not collapsed during a stall.
  - Handshakes are accepted only when valid & ready are both high on a rising edge. Outputs are stable while out_valid & ~out_ready.
- Reset (asynchronous, any time including mid-stream):
  - s1_valid = 0, out_valid = 0, out_fixed = 0, out_zero = 0, err = 0.
  - In-flight samples are discarded.
  - in_ready = 1 immediately after reset, since en = 1.
- Simultaneous accept and emit in the same cycle is the normal streaming case; there is no loss or duplication.

Optional Feature:
- Macro: RNG_F2U_ROUND_EN.
- Defined:
  - Stage 2 rounds half-up on the right shift: adds bit (e-1) of aligned when 1 <= e <= BY-1.
  - No overflow is possible, because for e >= 1 bit BY-1 of the shifted result is 0.
  - e == 0, e >= BY, and all flags are unchanged.
  - Latency is unchanged at 2 cycles.
- Undefined: pure truncation, and the rounding adder is not synthesised.

Test Plan (BY=32, MANT_BW=8, EXP_BW=6, out_ready=1 unless stated):
- e=0, m=0x00 -> out_fixed=0x80000000, out_zero=0, out_valid exactly 2 cycles after acceptance. Also e=0, m=0xFF -> 0xFF800000.
- e=3, m=0x80 -> 0x18000000. Also e=24, m=0x01 -> 0x00000080 (truncating), 0x00000081 with RNG_F2U_ROUND_EN. Also e=31, m=0xFF -> 0x00000001 truncating, 0x00000002 with rounding.
- e=32, any m -> out_fixed=0, out_zero=1, err=0. Then e=33 -> out_fixed=0, out_zero=1, err=1 and stays 1 across later valid samples until reset.
- Back-to-back stream of 8 samples with out_ready held low for cycles 3-5 -> in_ready=0 and outputs frozen during the stall. All 8 results emerge in order with no drop or duplicate.
- Assert reset asynchronously (mid-cycle) with 2 samples in flight -> out_valid, out_fixed, out_zero and err go to 0 without waiting for a clock edge. The next accepted sample appears 2 cycles after acceptance.
- Round trip: feed 10^4 uniform words through rng_uniform_to_float, then this block -> each output equals the input with bits below the retained mantissa cleared (truncating build).

Source files
------------

// File: rtl/rng_float_to_fixed.sv
// -----------------------------------------------------------------------------
// rng_float_to_fixed
//
// Decodes a packed RNG float sample {e, m} back into the BY-bit unsigned
// fixed-point fraction in [0,1) that it stands for. The binary point sits
// left of bit BY-1. e counts the leading zeros of the original uniform word
// and m holds the MANT_BW bits that follow its leading one. e == BY encodes
// an all-zero word. e > BY cannot come from a legal encoder, so it decodes
// to zero and raises the sticky err flag.
//
// Two-stage pipeline with a single global enable. A stall at the output
// freezes both stages and drops in_ready.
//
// Optional build macro:
//   RNG_F2U_ROUND_EN - when defined, stage 2 rounds half-up on the right shift
//                      instead of truncating. Latency is the same either way.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_valid  in   in_float carries a sample
//   in_ready  out  sample accepted this cycle when in_valid is also high
//   in_float  in   {e[EXP_BW-1:0], m[MANT_BW-1:0]}
//   out_valid out  out_fixed / out_zero hold a result
//   out_ready in   downstream accepts the result this cycle
//   out_fixed out  reconstructed BY-bit fraction
//   out_zero  out  sample decoded to exact zero (e >= BY)
//   err       out  sticky: some accepted sample had e > BY
// -----------------------------------------------------------------------------
module rng_float_to_fixed #(
  parameter int BY      = 32,
  parameter int MANT_BW = 8,
  parameter int EXP_BW  = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_BW+MANT_BW-1:0] in_float,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BY-1:0]             out_fixed,
  output logic                      out_zero,
  output logic                      err
);

  localparam int                FW   = EXP_BW + MANT_BW;
  localparam logic [EXP_BW-1:0] E_BY = EXP_BW'(BY);

  // One enable drives both stages: the pipe advances whenever the output
  // register is empty or being drained, otherwise everything holds.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Stage 1: split the fields and rebuild the normalised mantissa
  // ---------------------------------------------------------------------------
  logic [EXP_BW-1:0]  in_e;
  logic [MANT_BW-1:0] in_m;
  logic [BY-1:0]      in_aligned;

  assign in_e = in_float[FW-1:MANT_BW];
  assign in_m = in_float[MANT_BW-1:0];
  // Hidden one at bit BY-1 and the stored mantissa just below it. A shift is
  // used rather than a zero replication so MANT_BW+1 == BY still elaborates.
  assign in_aligned = BY'({1'b1, in_m}) << (BY - 1 - MANT_BW);

  logic              s1_valid;
  logic [EXP_BW-1:0] s1_e;
  logic [BY-1:0]     s1_aligned;
  logic              s1_over;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_e       <= '0;
      s1_aligned <= '0;
      s1_over    <= 1'b0;
    end else if (en) begin
      s1_valid   <= in_valid;
      s1_e       <= in_e;
      s1_aligned <= in_aligned;
      s1_over    <= (in_e > E_BY);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: barrel shift, optional rounding, zero / error detection
  // ---------------------------------------------------------------------------
  logic [BY-1:0] shifted;
  logic          zero_det;
  logic [BY-1:0] fixed_next;

  assign shifted  = s1_aligned >> s1_e;
  assign zero_det = (s1_e >= E_BY);

`ifdef RNG_F2U_ROUND_EN
  // Half-up rounding adds the most significant bit shifted out, i.e. bit
  // e-1 of the aligned value. For e >= 1 the top bit of the shifted value is
  // already clear, so the increment can never overflow.
  logic [BY-1:0] round_src;
  logic          round_bit;

  assign round_src = s1_aligned >> (s1_e - EXP_BW'(1));
  assign round_bit = (s1_e != '0) && (s1_e < E_BY) && round_src[0];
`endif

  // NOTE: fixed_next is given a default on entry so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    fixed_next = shifted;
`ifdef RNG_F2U_ROUND_EN
    fixed_next = shifted + BY'(round_bit);
`endif
    if (zero_det) begin
      fixed_next = '0;
    end
  end

  // NOTE: only control and output registers are reset here; the data path
  // has no storage arrays, so the whole visible state clears asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_fixed <= '0;
      out_zero  <= 1'b0;
      err       <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_fixed <= fixed_next;
      out_zero  <= zero_det;
      // err only reacts to real samples moving into the output register.
      if (s1_valid && s1_over) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rng_float_to_fixed.sv
// -----------------------------------------------------------------------------
// tb_rng_float_to_fixed
//
// Directed bench for rng_float_to_fixed at BY=32, MANT_BW=8, EXP_BW=6.
// Inputs are driven shortly after the rising edge and outputs are sampled
// either 1 ns after the edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_rng_float_to_fixed;

  localparam int BY      = 32;
  localparam int MANT_BW = 8;
  localparam int EXP_BW  = 6;

`ifdef RNG_F2U_ROUND_EN
  localparam logic [31:0] EXP_E24 = 32'h0000_0081;
  localparam logic [31:0] EXP_E31 = 32'h0000_0002;
`else
  localparam logic [31:0] EXP_E24 = 32'h0000_0080;
  localparam logic [31:0] EXP_E31 = 32'h0000_0001;
`endif

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [EXP_BW+MANT_BW-1:0] in_float = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic [BY-1:0]             out_fixed;
  logic                      out_zero;
  logic                      err;

  int n_checks = 0;
  int n_errors = 0;

  rng_float_to_fixed #(
    .BY      (BY),
    .MANT_BW (MANT_BW),
    .EXP_BW  (EXP_BW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_float  (in_float),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fixed (out_fixed),
    .out_zero  (out_zero),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single sample, called 1 ns after a rising edge; returns at the same phase
  // two edges later, having checked the 2-edge latency and the result.
  task automatic send_check(input string tag, input logic [5:0] e, input logic [7:0] m,
                            input logic [31:0] exp_fixed, input logic exp_zero,
                            input logic exp_err);
    in_valid = 1'b1;
    in_float = {e, m};
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_fixed"}, out_fixed, exp_fixed);
    check({tag, "_zero"}, 32'(out_zero), 32'(exp_zero));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  // Encoder model: leading-zero count and the MANT_BW bits after the leading one.
  function automatic logic [13:0] encode(input logic [31:0] w);
    int            e;
    logic [31:0]   sh;
    e = 32;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) begin
        e = 31 - i;
        break;
      end
    end
    sh = (e < 32) ? (w << e) : 32'd0;
    return {6'(e), sh[30:23]};
  endfunction

  // Stream vectors with hand-computed results (identical in both builds,
  // since no shifted-out bit is ever set for these).
  logic [5:0]  s_e   [8] = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd5};
  logic [7:0]  s_m   [8] = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h55, 8'h01, 8'h12, 8'h00};
  logic [31:0] s_fix [8] = '{32'h8000_0000, 32'h4000_0000, 32'h3FE0_0000, 32'h0C00_0000,
                             32'h00AA_8000, 32'h0000_8080, 32'h0000_0000, 32'h0400_0000};
  logic        s_zero[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fixed", out_fixed, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // ---------------- directed decode ----------------
    send_check("e0_m00", 6'd0, 8'h00, 32'h8000_0000, 1'b0, 1'b0);
    send_check("e0_mff", 6'd0, 8'hFF, 32'hFF80_0000, 1'b0, 1'b0);
    send_check("e3_m80", 6'd3, 8'h80, 32'h1800_0000, 1'b0, 1'b0);
    send_check("e24_m01", 6'd24, 8'h01, EXP_E24, 1'b0, 1'b0);
    send_check("e31_mff", 6'd31, 8'hFF, EXP_E31, 1'b0, 1'b0);
    send_check("e32", 6'd32, 8'hA5, 32'd0, 1'b1, 1'b0);
    send_check("e33", 6'd33, 8'h00, 32'd0, 1'b1, 1'b1);
    send_check("err_sticky", 6'd1, 8'h00, 32'h4000_0000, 1'b0, 1'b1);

    // ---------------- streaming with an output stall ----------------
    fork
      begin : driver
        for (int i = 0; i < 8; i++) begin
          int   guard;
          logic took;
          guard = 0;
          took  = 1'b0;
          in_valid = 1'b1;
          in_float = {s_e[i], s_m[i]};
          do begin
            @(negedge clock);
            took = in_ready;
            @(posedge clock); #2;
            guard++;
          end while (!took && guard < 20);
          check("drv_accept", 32'(took), 32'd1);
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int k;
        int c;
        k = 0;
        c = 0;
        while (k < 8 && c < 60) begin
          @(posedge clock);
          c++;
          #1;
          out_ready = !(c >= 3 && c <= 5);
          @(negedge clock);
          if (out_valid) begin
            check("stream_fixed", out_fixed, s_fix[k]);
            check("stream_zero", 32'(out_zero), 32'(s_zero[k]));
            if (!out_ready) begin
              check("stall_in_ready", 32'(in_ready), 32'd0);
            end else begin
              k++;
            end
          end
        end
        check("stream_count", 32'(k), 32'd8);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("stream_drain", 32'(out_valid), 32'd0);
      end
    join

    // ---------------- asynchronous reset with two samples in flight --------
    in_valid = 1'b1;
    in_float = {6'd33, 8'h00};
    @(posedge clock); #1;
    in_float = {6'd0, 8'h00};
    @(posedge clock); #3;
    in_valid = 1'b0;
    check("pre_rst_zero", 32'(out_zero), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_fixed", out_fixed, 32'd0);
    check("arst_out_zero", 32'(out_zero), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_flushed", 32'(out_valid), 32'd0);
    send_check("post_rst", 6'd3, 8'h80, 32'h1800_0000, 1'b0, 1'b0);

`ifndef RNG_F2U_ROUND_EN
    // ---------------- round trip through the encoder model ----------------
    for (int n = 0; n < 200; n++) begin
      logic [31:0] w;
      logic [13:0] f;
      logic [31:0] mask;
      if (n == 0)      w = 32'd0;
      else if (n == 1) w = 32'd1;
      else if (n == 2) w = 32'hFFFF_FFFF;
      else             w = $urandom >> $urandom_range(0, 31);
      f    = encode(w);
      mask = 32'hFF80_0000 >> f[13:8];
      send_check("round_trip", f[13:8], f[7:0], w & mask, (w == 32'd0), 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
